fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants for the fetch stage: NOP encoding, PC step and
// the fetch FSM state type.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one imem request at a time, buffers the
// returned instruction in a single registered entry that feeds IF/ID, and
// restarts fetch on redirect (discarding any in-flight response).
// Optional build macro: FETCH_PERF_CNT_EN adds fetch/bubble counters.
//
// state | meaning
// REQ   | request driven at pc (unless buffer full under stall)
// WAIT  | one request outstanding, waiting for its response
// HOLD  | buffer full, waiting for stall release
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   BUS_WIDTH   = 64,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [BUS_WIDTH-1:0]   redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [BUS_WIDTH-1:0]   imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  output logic [BUS_WIDTH-1:0]   out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   out_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_bubble_cnt
`endif
);

  fetch_state_e           state_q, state_d;
  logic [BUS_WIDTH-1:0]   pc_q, pc_d;
  logic [BUS_WIDTH-1:0]   buf_pc_q, buf_pc_d;
  logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic                   buf_valid_q, buf_valid_d;
  logic                   drop_q, drop_d;
  logic                   req_fire;
  logic                   load_en;

  // Request is suppressed in reset, while a stale response is pending, and
  // when the buffer is full and cannot drain this cycle.
  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && state_q == ST_REQ && !drop_q && (!buf_valid_q || !stall)) begin
      imem_req_valid = 1'b1;
    end
  end

  assign imem_req_addr = pc_q;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign load_en       = (state_q == ST_WAIT) && imem_resp_valid && !drop_q && !redirect_valid;

  // Next-state: FSM, buffer drain/refill, pc advance, redirect override.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    buf_valid_d = buf_valid_q;
    drop_d      = drop_q;

    if (!stall) begin
      buf_valid_d = 1'b0;
    end
    if (drop_q && imem_resp_valid) begin
      drop_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (buf_valid_q && stall) begin
          state_d = ST_HOLD;
        end else if (req_fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (load_en) begin
          buf_valid_d = 1'b1;
          buf_pc_d    = pc_q;
          buf_instr_d = imem_resp_data;
          pc_d        = pc_q + BUS_WIDTH'(PC_INC);
          state_d     = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // A request still in flight (or accepted right now) will return data for
    // the old path; remember to throw that one response away.
    if (redirect_valid) begin
      buf_valid_d = 1'b0;
      pc_d        = redirect_pc;
      state_d     = ST_REQ;
      drop_d      = req_fire
                 || (state_q == ST_WAIT && !imem_resp_valid)
                 || (drop_q && !imem_resp_valid);
    end
  end

  // State and buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      buf_pc_q    <= RESET_PC;
      buf_instr_q <= INSTR_WIDTH'(NOP_INSTR);
      buf_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_valid_q <= buf_valid_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid = buf_valid_q;
  assign out_pc    = buf_valid_q ? buf_pc_q : pc_q;
  assign out_instr = buf_valid_q ? buf_instr_q : INSTR_WIDTH'(NOP_INSTR);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Count buffered instructions and unstalled cycles with an empty buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (load_en) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!stall && !buf_valid_q) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem responder model, expected-stream
// scoreboard, directed corner cases and a randomized phase.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_pc(out_pc), .out_instr(out_instr), .out_valid(out_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_capt = 0;
  int m_fetch = 0;
  int m_bubble = 0;
  bit rand_mode = 0;
  int fix_lat = 0;
  logic [63:0] exp_q[$];
  logic [63:0] next_exp = '0;
  logic [63:0] addr_log[$];

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Expected delivery stream: sequential from the last restart point.
  task automatic model_topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 64'd4;
    end
  endtask

  task automatic model_restart(input logic [63:0] pc);
    exp_q.delete();
    next_exp = pc;
    model_topup();
  endtask

  task automatic step();
    @(posedge clk); #2;
    model_topup();
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    model_restart(pc);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, NOP);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_req_valid", imem_req_valid, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 0);
    chk("rst_perf_bubble", perf_bubble_cnt, 0);
`endif
    model_restart(64'h0);
    m_fetch = 0; m_bubble = 0;
    addr_log.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Instruction memory: one response per accepted request, in order.
  initial begin
    logic        req_s, resp_s, pend;
    logic [63:0] addr_s, pend_addr;
    int          lat;
    pend = 0; pend_addr = '0; lat = 0;
    forever begin
      @(negedge clk);
      req_s = imem_req_valid && imem_req_ready;
      resp_s = imem_resp_valid;
      addr_s = imem_req_addr;
      @(posedge clk); #1;
      if (rst) begin
        pend = 0;
        imem_resp_valid = 1'b0;
      end else begin
        if (req_s) chk("one_outstanding", pend && !resp_s, 0);
        if (resp_s) pend = 0;
        if (req_s) begin
          pend = 1; pend_addr = addr_s;
          lat = rand_mode ? int'($urandom_range(0, 2)) : fix_lat;
          addr_log.push_back(addr_s);
        end else if (pend && lat > 0) begin
          lat--;
        end
        imem_resp_valid = pend && (lat == 0);
        imem_resp_data = mem_f(pend_addr);
      end
      imem_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Scoreboard monitor: compares each IF/ID capture with the expected stream.
  initial begin
    logic prev_v, prev_c;
    logic [63:0] e;
    prev_v = 0; prev_c = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 0; prev_c = 0;
        continue;
      end
      if (out_valid && (!prev_v || prev_c)) m_fetch++;
      if (!stall && !out_valid) m_bubble++;
      if (out_valid && !stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL scb_underflow: got pc %h with no expected entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("scb_pc", out_pc, e);
          chk("scb_instr", {32'h0, out_instr}, {32'h0, mem_f(e)});
          n_capt++;
        end
      end
      if (!out_valid) chk("nop_when_empty", {32'h0, out_instr}, {32'h0, NOP});
      prev_v = out_valid;
      prev_c = out_valid && (!stall || redirect_valid);
    end
  end

  initial begin
    bit ok;
    int nresp;
    bit pend_chk;
    logic [63:0] hp, hi, rp;
    int idx;

    // Sequential fetch after reset with 1-cycle latency.
    apply_reset();
    nresp = 0; pend_chk = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pend_chk) begin
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_pc", out_pc, 64'(4 * (nresp - 1)));
        pend_chk = 0;
      end
      if (imem_resp_valid) begin nresp++; pend_chk = 1; end
      step();
    end
    if (addr_log.size() >= 3) begin
      chk("addr0", addr_log[0], 64'h0);
      chk("addr1", addr_log[1], 64'h4);
      chk("addr2", addr_log[2], 64'h8);
    end else chk("addr_count", addr_log.size(), 3);

    // Buffer full under stall: HOLD, no request, outputs stable.
    stall = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1; else step();
    end
    chk("hold_fill_timeout", ok, 1);
    hp = out_pc; hi = {32'h0, out_instr};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin step(); @(negedge clk); end
      chk("hold_req_valid", imem_req_valid, 0);
      chk("hold_out_pc", out_pc, hp);
      chk("hold_out_instr", {32'h0, out_instr}, hi);
    end
    step(); stall = 1'b0;
    step(); @(negedge clk);
    chk("resume_req_valid", imem_req_valid, 1);
    chk("resume_req_addr", imem_req_addr, hp + 64'd4);

    // Redirect while a request is outstanding: stale response dropped.
    fix_lat = 2;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(); @(negedge clk);
      if (imem_req_valid && imem_req_ready) ok = 1;
    end
    chk("wait_accept_timeout", ok, 1);
    step(); do_redirect(64'h1000);
    @(negedge clk);
    step(); redirect_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 6 && !ok; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk("drop_out_valid", out_valid, 0);
      chk("drop_out_instr", {32'h0, out_instr}, {32'h0, NOP});
      chk("drop_out_pc", out_pc, 64'h1000);
      chk("drop_no_req", imem_req_valid, 0);
      if (imem_resp_valid) ok = 1;
    end
    chk("drop_resp_timeout", ok, 1);
    step(); @(negedge clk);
    chk("drop_after_valid", out_valid, 0);
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_req_addr", imem_req_addr, 64'h1000);
    fix_lat = 0;

    // Redirect with stall and a full buffer.
    step(); stall = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1; else step();
    end
    chk("rs_fill_timeout", ok, 1);
    step(); do_redirect(64'h2000);
    @(negedge clk);
    step(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("rs_out_valid", out_valid, 0);
    chk("rs_out_instr", {32'h0, out_instr}, {32'h0, NOP});
    chk("rs_out_pc", out_pc, 64'h2000);
    chk("rs_req_addr", imem_req_addr, 64'h2000);
    step(); stall = 1'b0;

    // PC wrap at the top of the address space.
    step(); do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    step(); redirect_valid = 1'b0;
    repeat (10) step();
    idx = -1;
    for (int i = 0; i < addr_log.size(); i++)
      if (idx < 0 && addr_log[i] == 64'hFFFF_FFFF_FFFF_FFFC) idx = i;
    chk("wrap_found", idx >= 0, 1);
    if (idx >= 0 && idx + 1 < addr_log.size()) chk("wrap_next_addr", addr_log[idx + 1], 64'h0);
    else chk("wrap_next_present", addr_log.size(), idx + 2);

    // Reset asserted while waiting on a response.
    fix_lat = 2;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(); @(negedge clk);
      if (imem_req_valid && imem_req_ready) ok = 1;
    end
    chk("rst_wait_timeout", ok, 1);
    apply_reset();
    fix_lat = 0;

    // Randomized traffic: ready, latency, stall and redirects.
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      stall = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 4) begin
        rp = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
          0: rp = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
          1: ;
          default: rp[1:0] = 2'b00;
        endcase
        do_redirect(rp);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    step();
    chk("captures_seen", n_capt > 100, 1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetch));
    chk("perf_bubble_cnt", perf_bubble_cnt, 32'(m_bubble));
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
